hpdcache_sram_wbyteenable_rmw_1rw: RTL and testbench
====================================================

HPDCACHE_SRAM_WBYTEENABLE_RMW_1RW -- requirements
Module: hpdcache_sram_wbyteenable_rmw_1rw

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 0, word address width.
REQ-002 SHALL have parameter DATA_SIZE, default 0, word width in bits; multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_SIZE, number of words.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cs, input, 1, request valid.
REQ-007 SHALL have port we, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port addr, input, ADDR_SIZE, word address.
REQ-009 SHALL have port wdata, input, DATA_SIZE, write data.
REQ-010 SHALL have port wbyteenable, input, DATA_SIZE/8, bit i enables byte i (bits 8i+7:8i).
REQ-011 SHALL have port ready, output, 1, request accepted when cs and ready are both 1.
REQ-012 SHALL have port rdata, output, DATA_SIZE, read data.

Function
REQ-013 SHALL target a mask-less 1RW macro, emulating byte enables by read-modify-write (RMW).
REQ-014 SHALL implement FSM states IDLE and RMW_WRITE; ready = 1 only in IDLE.
REQ-015 IDLE, accepted read: macro read issued same cycle; rdata valid next cycle; stay IDLE.
REQ-016 IDLE, accepted write with all enables 1: macro written same cycle; stay IDLE; 1-cycle occupancy.
REQ-017 IDLE, accepted write with all enables 0: no macro access; stay IDLE.
REQ-018 IDLE, accepted partial write: capture addr, wdata, wbyteenable; issue internal macro read; go to RMW_WRITE.
REQ-019 RMW_WRITE: write byte-wise merge (enabled bytes from captured wdata, others from macro read data) to captured addr; return to IDLE next cycle.
REQ-020 Partial write SHALL occupy exactly 2 cycles; a request presented during RMW_WRITE is not accepted and must be held.
REQ-021 rdata SHALL reflect the most recent accepted external read and hold until the next one; internal RMW reads SHALL NOT alter rdata.
REQ-022 Read of an address in the cycle right after its RMW completes SHALL return the merged data (no forwarding needed; macro already written).
REQ-023 cs = 0 SHALL issue no macro access; inputs are ignored when cs = 0 or ready = 0.
REQ-024 Addresses >= DEPTH are illegal; behaviour undefined, flagged by a simulation-only assertion.

Reset
REQ-025 Reset SHALL force IDLE, ready = 1, rdata hold register = 0, captured request cleared.
REQ-026 Reset during RMW_WRITE SHALL abort the RMW before the macro write; target word remains at its pre-write value.
REQ-027 No macro access SHALL be issued while rst_n = 0.

Structure
REQ-028 FSM state enum type SHALL reside in the shared hpdcache package.
REQ-029 SHALL instantiate one sub-module hpdcache_sram_1rw (plain macro, no mask) of ADDR_SIZE x DATA_SIZE.
REQ-030 Merge logic SHALL be a generate loop over DATA_SIZE/8 byte lanes; no arithmetic beyond byte selection.

Verification (ADDR_SIZE = 6, DATA_SIZE = 64)
REQ-031 Full write 0x1122334455667788, be 0xFF, addr 5; read addr 5 -> ready stays 1, rdata = 0x1122334455667788 one cycle after read.
REQ-032 Then partial write 0xAAAAAAAAAAAAAAAA, be 0x0F, addr 5 -> ready = 0 for one cycle; read addr 5 -> 0x11223344AAAAAAAA.
REQ-033 Read addr 5 (rdata X), then partial write addr 9 -> rdata stays X through RMW cycles.
REQ-034 Write be 0x00 to addr 5 -> no macro access, ready stays 1, contents unchanged.
REQ-035 Assert rst_n = 0 in RMW_WRITE of partial write addr 5 -> after reset ready = 1, rdata = 0, addr 5 holds pre-write value.
REQ-036 Back-to-back partial writes addr 1 and addr 2 with cs held -> second accepted only after first completes; both merges correct.

Source files
------------

// File: rtl/hpdcache_pkg.sv
// Shared hpdcache definitions: RMW sequencer state and byte-lane geometry.
package hpdcache_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } hpdcache_rmw_state_e;

    localparam int unsigned HPDCACHE_BYTE_BITS = 8;

endpackage

// File: rtl/hpdcache_sram_1rw.sv
// Plain single-port SRAM macro model: no write mask, synchronous read, read data held until next read.
module hpdcache_sram_1rw #(
    parameter int unsigned ADDR_SIZE = 0,
    parameter int unsigned DATA_SIZE = 0,
    parameter int unsigned DEPTH     = 2**ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 cs,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_SIZE-1:0] wdata,
    output logic [DATA_SIZE-1:0] rdata
);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (cs) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/hpdcache_sram_wbyteenable_rmw_1rw.sv
// Byte-enable SRAM built on a mask-less 1RW macro: partial writes become a read then a merged write.
module hpdcache_sram_wbyteenable_rmw_1rw
    import hpdcache_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 0,
    parameter int unsigned DATA_SIZE = 0,
    parameter int unsigned DEPTH     = 2**ADDR_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cs,
    input  logic                   we,
    input  logic [ADDR_SIZE-1:0]   addr,
    input  logic [DATA_SIZE-1:0]   wdata,
    input  logic [DATA_SIZE/8-1:0] wbyteenable,
    output logic                   ready,
    output logic [DATA_SIZE-1:0]   rdata
);

    localparam int unsigned BE_SIZE = DATA_SIZE / HPDCACHE_BYTE_BITS;

    hpdcache_rmw_state_e  state;
    logic [ADDR_SIZE-1:0] cap_addr;
    logic [DATA_SIZE-1:0] cap_wdata;
    logic [BE_SIZE-1:0]   cap_be;
    logic                 rd_pending;
    logic [DATA_SIZE-1:0] rdata_q;

    logic                 mac_cs;
    logic                 mac_we;
    logic [ADDR_SIZE-1:0] mac_addr;
    logic [DATA_SIZE-1:0] mac_wdata;
    logic [DATA_SIZE-1:0] mac_rdata;
    logic [DATA_SIZE-1:0] merged;
    logic                 be_full;
    logic                 be_none;

    assign be_full = &wbyteenable;
    assign be_none = ~|wbyteenable;
    assign ready   = (state == IDLE);

    generate
        for (genvar i = 0; i < BE_SIZE; i++) begin : gen_merge_lane
            assign merged[i*8 +: 8] = cap_be[i] ? cap_wdata[i*8 +: 8] : mac_rdata[i*8 +: 8];
        end
    endgenerate

    // Gating with rst_n keeps the macro idle during reset, which also aborts an in-flight RMW write.
    always_comb begin
        mac_cs    = 1'b0;
        mac_we    = 1'b0;
        mac_addr  = addr;
        mac_wdata = wdata;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (cs) begin
                        if (!we) begin
                            mac_cs = 1'b1;
                        end else if (be_full) begin
                            mac_cs = 1'b1;
                            mac_we = 1'b1;
                        end else if (!be_none) begin
                            mac_cs = 1'b1;
                        end
                    end
                end
                RMW_WRITE: begin
                    mac_cs    = 1'b1;
                    mac_we    = 1'b1;
                    mac_addr  = cap_addr;
                    mac_wdata = merged;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_be     <= '0;
            rd_pending <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rd_pending <= 1'b0;
            if (rd_pending) begin
                rdata_q <= mac_rdata;
            end
            case (state)
                IDLE: begin
                    if (cs) begin
                        if (!we) begin
                            rd_pending <= 1'b1;
                        end else if (!be_full && !be_none) begin
                            cap_addr  <= addr;
                            cap_wdata <= wdata;
                            cap_be    <= wbyteenable;
                            state     <= RMW_WRITE;
                        end
                    end
                end
                RMW_WRITE: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Only the cycle right after an external read exposes the macro output; RMW reads never reach rdata.
    assign rdata = rd_pending ? mac_rdata : rdata_q;

    addr_in_range_a: assert property (@(posedge clk) disable iff (!rst_n)
        (cs && ready) |-> (32'(addr) < DEPTH));

    hpdcache_sram_1rw #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) i_sram (
        .clk   (clk),
        .cs    (mac_cs),
        .we    (mac_we),
        .addr  (mac_addr),
        .wdata (mac_wdata),
        .rdata (mac_rdata)
    );

endmodule

// File: tb/tb_hpdcache_sram_wbyteenable_rmw_1rw.sv
// Directed self-checking bench for the RMW byte-enable SRAM wrapper (64-bit words, 64 entries).
module tb_hpdcache_sram_wbyteenable_rmw_1rw;

    localparam int unsigned ADDR_SIZE = 6;
    localparam int unsigned DATA_SIZE = 64;

    logic                   clk;
    logic                   rst_n;
    logic                   cs;
    logic                   we;
    logic [ADDR_SIZE-1:0]   addr;
    logic [DATA_SIZE-1:0]   wdata;
    logic [DATA_SIZE/8-1:0] wbyteenable;
    logic                   ready;
    logic [DATA_SIZE-1:0]   rdata;

    int checkCount = 0;
    int passCount  = 0;

    hpdcache_sram_wbyteenable_rmw_1rw #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .wbyteenable (wbyteenable),
        .ready       (ready),
        .rdata       (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic c, input logic w, input logic [ADDR_SIZE-1:0] a,
                                 input logic [DATA_SIZE-1:0] d, input logic [DATA_SIZE/8-1:0] be);
        cs          = c;
        we          = w;
        addr        = a;
        wdata       = d;
        wbyteenable = be;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DATA_SIZE-1:0] observed,
                               input logic [DATA_SIZE-1:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    endtask

    // Single-cycle external read; leaves the bus idle so rdata can be checked right after.
    task automatic readWord(input logic [ADDR_SIZE-1:0] a);
        applyStimulus(1'b1, 1'b0, a, '0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("reset_ready", 64'(ready), 64'd1);
        checkOutput("reset_rdata", rdata, 64'h0);
        rst_n = 1'b1;
        tick();

        applyStimulus(1'b1, 1'b1, 6'd5, 64'h1122334455667788, 8'hFF);
        tick();
        checkOutput("full_write_ready", 64'(ready), 64'd1);
        readWord(6'd5);
        checkOutput("full_write_readback", rdata, 64'h1122334455667788);
        checkOutput("read_ready", 64'(ready), 64'd1);

        applyStimulus(1'b1, 1'b1, 6'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        tick();
        checkOutput("partial_busy_ready", 64'(ready), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("partial_done_ready", 64'(ready), 64'd1);
        readWord(6'd5);
        checkOutput("partial_merge_addr5", rdata, 64'h11223344AAAAAAAA);

        applyStimulus(1'b1, 1'b1, 6'd9, 64'hFFEEDDCCBBAA9988, 8'hFF);
        tick();
        readWord(6'd5);
        checkOutput("read_before_rmw", rdata, 64'h11223344AAAAAAAA);
        applyStimulus(1'b1, 1'b1, 6'd9, 64'h0123456789ABCDEF, 8'hF0);
        tick();
        checkOutput("rdata_hold_rmw_read", rdata, 64'h11223344AAAAAAAA);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("rdata_hold_rmw_write", rdata, 64'h11223344AAAAAAAA);
        readWord(6'd9);
        checkOutput("partial_merge_addr9", rdata, 64'h01234567BBAA9988);

        applyStimulus(1'b1, 1'b1, 6'd5, 64'hDEADBEEFDEADBEEF, 8'h00);
        tick();
        checkOutput("empty_be_ready", 64'(ready), 64'd1);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        readWord(6'd5);
        checkOutput("empty_be_unchanged", rdata, 64'h11223344AAAAAAAA);

        applyStimulus(1'b1, 1'b1, 6'd5, 64'h5555555555555555, 8'hF0);
        tick();
        checkOutput("abort_in_rmw_ready", 64'(ready), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_reset_ready", 64'(ready), 64'd1);
        checkOutput("abort_reset_rdata", rdata, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("abort_after_ready", 64'(ready), 64'd1);
        readWord(6'd5);
        checkOutput("abort_addr5_kept", rdata, 64'h11223344AAAAAAAA);

        applyStimulus(1'b1, 1'b1, 6'd1, 64'h0101010101010101, 8'hFF);
        tick();
        applyStimulus(1'b1, 1'b1, 6'd2, 64'h0202020202020202, 8'hFF);
        tick();
        applyStimulus(1'b1, 1'b1, 6'd1, 64'h00000000000000EE, 8'h01);
        tick();
        checkOutput("b2b_first_busy", 64'(ready), 64'd0);
        applyStimulus(1'b1, 1'b1, 6'd2, 64'hCC00000000000000, 8'h80);
        tick();
        checkOutput("b2b_first_done", 64'(ready), 64'd1);
        tick();
        checkOutput("b2b_second_busy", 64'(ready), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("b2b_second_done", 64'(ready), 64'd1);
        readWord(6'd1);
        checkOutput("b2b_merge_addr1", rdata, 64'h01010101010101EE);
        readWord(6'd2);
        checkOutput("b2b_merge_addr2", rdata, 64'hCC02020202020202);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
